// File: rtl/counter_pkg.sv
// Shared types and defaults for the multi-channel modulo counter bank.
// Channel mode selects what happens when a count step hits a boundary.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;

endpackage

// File: rtl/counter_channel.sv
// One modulo counter channel: up/down count with clear, clamped load,
// programmable limit, wrap/saturate boundary handling, tc pulse, sticky ovf.
module counter_channel
  import counter_pkg::*;
#(
  parameter int        WIDTH = DEF_WIDTH,
  parameter cnt_mode_e MODE  = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             down,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             tc_reg;
  logic             tc_next;
  logic             ovf_reg;
  logic             ovf_next;
  logic             up_boundary;
  logic             down_boundary;
  logic [WIDTH-1:0] load_clamped;

  // >= rather than == so a count left above a lowered limit still terminates.
  assign up_boundary   = (count_reg >= limit);
  assign down_boundary = (count_reg == '0);
  assign load_clamped  = (load_val > limit) ? limit : load_val;

  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    ovf_next   = ovf_reg;
    if (clr) begin
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (load) begin
      count_next = load_clamped;
    end else if (en) begin
      if (!down) begin
        if (up_boundary) begin
          count_next = (MODE == CNT_SAT) ? limit : '0;
          tc_next    = 1'b1;
          ovf_next   = 1'b1;
        end else begin
          count_next = count_reg + WIDTH'(1);
        end
      end else begin
        if (down_boundary) begin
          count_next = (MODE == CNT_SAT) ? '0 : limit;
          tc_next    = 1'b1;
          ovf_next   = 1'b1;
        end else begin
          count_next = count_reg - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign count = count_reg;
  assign tc    = tc_reg;
  assign ovf   = ovf_reg;

endmodule

// File: rtl/multi_mod_counter.sv
// Bank of NCH independent modulo counters; each channel's mode comes from
// the matching SAT_MASK bit, and packed ports are sliced per channel.
module multi_mod_counter
  import counter_pkg::*;
#(
  parameter int             WIDTH    = DEF_WIDTH,
  parameter int             NCH      = DEF_NCH,
  parameter logic [NCH-1:0] SAT_MASK = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       clr,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] load_val,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       down,
  input  logic [NCH*WIDTH-1:0] limit,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH-1:0]       tc,
  output logic [NCH-1:0]       ovf
);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      localparam cnt_mode_e MODE = cnt_mode_e'(SAT_MASK[gi]);

      counter_channel #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
      ) u_channel (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr[gi]),
        .load     (load[gi]),
        .load_val (load_val[gi*WIDTH +: WIDTH]),
        .en       (en[gi]),
        .down     (down[gi]),
        .limit    (limit[gi*WIDTH +: WIDTH]),
        .count    (count[gi*WIDTH +: WIDTH]),
        .tc       (tc[gi]),
        .ovf      (ovf[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_mod_counter.sv
// Bench for multi_mod_counter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an arithmetic model.
module tb_multi_mod_counter;

  localparam int             W    = 8;
  localparam int             NCH  = 4;
  localparam logic [NCH-1:0] MASK = 4'b1010;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       clr, load, en, down;
  logic [NCH*W-1:0]     load_val, limit;
  logic [NCH*W-1:0]     count;
  logic [NCH-1:0]       tc, ovf;

  int total = 0;
  int bad   = 0;

  multi_mod_counter #(.WIDTH(W), .NCH(NCH), .SAT_MASK(MASK)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .down     (down),
    .limit    (limit),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt(input int ch);
    return int'(count[ch*W +: W]);
  endfunction

  // Reference model: plain integers following the channel rules.
  int m_cnt [NCH];
  int m_tc  [NCH];
  int m_ovf [NCH];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        int lim, lv, top;
        bit sat;
        lim = int'(limit[i*W +: W]);
        lv  = int'(load_val[i*W +: W]);
        sat = MASK[i];
        m_tc[i] = 0;
        if (clr[i]) begin
          m_cnt[i] = 0; m_ovf[i] = 0;
        end else if (load[i]) begin
          m_cnt[i] = (lv < lim) ? lv : lim;
        end else if (en[i]) begin
          if (!down[i]) begin
            if (m_cnt[i] >= lim) begin
              m_cnt[i] = sat ? lim : 0; m_tc[i] = 1; m_ovf[i] = 1;
            end else begin
              m_cnt[i] = m_cnt[i] + 1;
            end
          end else begin
            if (m_cnt[i] == 0) begin
              top = lim;
              m_cnt[i] = sat ? 0 : top; m_tc[i] = 1; m_ovf[i] = 1;
            end else begin
              m_cnt[i] = m_cnt[i] - 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("model_count[%0d]", i), cnt(i), m_cnt[i]);
        chk($sformatf("model_tc[%0d]", i), int'(tc[i]), m_tc[i]);
        chk($sformatf("model_ovf[%0d]", i), int'(ovf[i]), m_ovf[i]);
      end
    end
  end

  task automatic idle();
    clr = '0; load = '0; en = '0; down = '0;
  endtask

  task automatic set_limit(input int ch, input int v);
    limit[ch*W +: W] = W'(v);
  endtask

  task automatic set_lv(input int ch, input int v);
    load_val[ch*W +: W] = W'(v);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int exp_seq [7] = '{1, 2, 3, 4, 5, 0, 1};
  int sat_seq [4] = '{1, 0, 0, 0};

  initial begin
    rst = 1'b1; idle(); load_val = '0; limit = '0;
    tick();
    chk("reset_count", int'(count), 0);
    chk("reset_tc", int'(tc), 0);
    chk("reset_ovf", int'(ovf), 0);
    rst = 1'b0;

    // Reset mid-count
    set_limit(0, 100); set_lv(0, 37); load[0] = 1'b1;
    tick();
    chk("mid_load", cnt(0), 37);
    idle(); en[0] = 1'b1;
    tick();
    chk("mid_up", cnt(0), 38);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", cnt(0), 0);
    chk("mid_rst_tc", int'(tc[0]), 0);
    chk("mid_rst_ovf", int'(ovf[0]), 0);

    // Wrap up, limit 5
    idle(); clr[0] = 1'b1;
    tick();
    idle(); set_limit(0, 5); en[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("wrap_count_%0d", k), cnt(0), exp_seq[k]);
      chk($sformatf("wrap_tc_%0d", k), int'(tc[0]), (k == 5) ? 1 : 0);
      chk($sformatf("wrap_ovf_%0d", k), int'(ovf[0]), (k >= 5) ? 1 : 0);
    end

    // Saturate down on ch1
    idle(); set_limit(1, 10); set_lv(1, 2); load[1] = 1'b1;
    tick();
    chk("sat_load", cnt(1), 2);
    idle(); en[1] = 1'b1; down[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("sat_count_%0d", k), cnt(1), sat_seq[k]);
      chk($sformatf("sat_tc_%0d", k), int'(tc[1]), (k >= 2) ? 1 : 0);
    end

    // Load clamp and clear priority on ch2
    idle(); set_limit(2, 10); set_lv(2, 200); load[2] = 1'b1; en[2] = 1'b1;
    tick();
    chk("clamp_count", cnt(2), 10);
    chk("clamp_tc", int'(tc[2]), 0);
    idle(); en[2] = 1'b1;
    tick();
    chk("clamp_wrap_ovf", int'(ovf[2]), 1);
    idle(); clr[2] = 1'b1; load[2] = 1'b1; en[2] = 1'b1;
    tick();
    chk("clr_prio_count", cnt(2), 0);
    chk("clr_prio_ovf", int'(ovf[2]), 0);

    // Limit lowered under the count, then limit 0
    idle(); set_limit(2, 20); set_lv(2, 9); load[2] = 1'b1;
    tick();
    chk("lim_load", cnt(2), 9);
    idle(); set_limit(2, 4); en[2] = 1'b1;
    tick();
    chk("lim_drop_count", cnt(2), 0);
    chk("lim_drop_tc", int'(tc[2]), 1);
    set_limit(2, 0);
    for (int k = 0; k < 5; k++) begin
      down[2] = (k >= 3);
      tick();
      chk($sformatf("lim0_count_%0d", k), cnt(2), 0);
      chk($sformatf("lim0_tc_%0d", k), int'(tc[2]), 1);
    end

    // Independence across channels
    idle();
    set_limit(0, 3); set_lv(0, 3); load[0] = 1'b1;
    set_limit(1, 10); set_lv(1, 5); load[1] = 1'b1;
    set_limit(3, 10); set_lv(3, 7); load[3] = 1'b1;
    tick();
    idle(); en[0] = 1'b1; clr[1] = 1'b1;
    tick();
    chk("indep_tc", int'(tc), 1);
    chk("indep_ch0", cnt(0), 0);
    chk("indep_ch1", cnt(1), 0);
    chk("indep_ch1_ovf", int'(ovf[1]), 0);
    chk("indep_ch3", cnt(3), 7);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NCH; i++) begin
        clr[i]  = ($urandom_range(0, 15) == 0);
        load[i] = ($urandom_range(0, 7) == 0);
        en[i]   = ($urandom_range(0, 3) != 0);
        down[i] = $urandom_range(0, 1);
        set_lv(i, $urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0)
          set_limit(i, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255)
                                                   : $urandom_range(0, 12));
      end
      tick();
    end
    rst = 1'b0; idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
